// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port among NUM_REQ renderers.
// A one-hot tag pipeline follows each grant so returned data is steered to its owner.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 12,
  parameter int RAM_LATENCY = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic [ADDR_WIDTH-1:0]         ram_addr_out,
  input  logic [DATA_WIDTH-1:0]         ram_data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [NUM_REQ-1:0]            valid_out,
  output logic                          busy_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = RAM_LATENCY + 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      gidx;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]    valid_q, valid_d;
  logic [NUM_REQ-1:0]    tag_q [DEPTH];
  int                    idx;

  // Search starts at ptr and wraps; the first requesting index wins.
  always_comb begin
    grant_out = '0;
    gidx      = '0;
    accept    = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!accept && req_in[idx]) begin
        grant_out[idx] = 1'b1;
        gidx           = PTR_W'(idx);
        accept         = 1'b1;
      end
    end
    if (!rst_in) begin
      grant_out = '0;
      accept    = 1'b0;
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    ram_addr_d = ram_addr_q;
    if (accept) begin
      ptr_d      = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      ram_addr_d = addr_in[gidx*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Data is captured only when the oldest tag is live; otherwise the bus holds.
  always_comb begin
    data_d  = data_q;
    valid_d = tag_q[DEPTH-1];
    if (|tag_q[DEPTH-1]) data_d = ram_data_in;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ptr_q      <= '0;
      ram_addr_q <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      ram_addr_q <= ram_addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      tag_q[0]   <= grant_out & req_in;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    busy_out = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_out = busy_out | (|tag_q[i]);
  end

  assign ram_addr_out = ram_addr_q;
  assign data_out     = data_q;
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: vector table, directed corner sequences and a
// queue scoreboard fed by an independent grant/return model.
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int RL = 2;
  localparam int LAT = RL + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N-1:0]    grant;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data;
  logic [DW-1:0]   dout;
  logic [N-1:0]    vld;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(RL)) dut (
    .clk_in(clk), .rst_in(rst_n), .req_in(req), .addr_in(addr), .grant_out(grant),
    .ram_addr_out(ram_addr), .ram_data_in(ram_data), .data_out(dout), .valid_out(vld),
    .busy_out(busy)
  );

  // ROM model: data = addr ^ 0xFFF, RL cycles after the address
  logic [DW-1:0] rp0, rp1;
  always @(posedge clk) begin
    rp0 <= ram_addr ^ 12'hFFF;
    rp1 <= rp0;
  end
  assign ram_data = rp1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct { logic [N-1:0] tag; logic [DW-1:0] data; int due; } exp_t;
  exp_t sbq[$];
  exp_t e;
  int   cyc = 0;
  int   mptr = 0;
  int   gi;
  int   waits [N];
  logic [N-1:0] eg;

  always @(negedge clk) begin
    cyc++;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("sb_valid", 32'(vld), 32'(e.tag));
      chk("sb_data", 32'(dout), 32'(e.data));
    end else begin
      chk("sb_idle_valid", 32'(vld), 32'd0);
    end
    chk("sb_busy", 32'(busy), 32'(sbq.size() > 0));
    eg = '0;
    gi = -1;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        if (gi < 0 && req[(mptr + k) % N]) gi = (mptr + k) % N;
      end
      if (gi >= 0) eg[gi] = 1'b1;
    end
    chk("sb_grant", 32'(grant), 32'(eg));
    if (!rst_n) begin
      sbq.delete();
      mptr = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      if (gi >= 0) begin
        e.tag  = eg;
        e.data = addr[gi*AW +: AW] ^ 12'hFFF;
        e.due  = cyc + LAT;
        sbq.push_back(e);
        mptr = (gi + 1) % N;
        chk("sb_wait_bound", 32'(waits[gi] <= N - 1), 32'd1);
      end
      for (int i = 0; i < N; i++) waits[i] = (req[i] && !eg[i]) ? waits[i] + 1 : 0;
    end
  end

  typedef struct { logic rst; logic [N-1:0] req; logic [N-1:0] exp_grant; } vec_t;
  vec_t vecs[12];
  logic [N-1:0] g;

  initial begin
    vecs[0]  = '{1'b0, 4'b1111, 4'b0000};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000};
    vecs[3]  = '{1'b1, 4'b1111, 4'b0001};
    vecs[4]  = '{1'b1, 4'b1111, 4'b0010};
    vecs[5]  = '{1'b1, 4'b0100, 4'b0100};
    vecs[6]  = '{1'b1, 4'b1001, 4'b1000};
    vecs[7]  = '{1'b1, 4'b1001, 4'b0001};
    vecs[8]  = '{1'b1, 4'b0000, 4'b0000};
    vecs[9]  = '{1'b1, 4'b0001, 4'b0001};
    vecs[10] = '{1'b1, 4'b0011, 4'b0010};
    vecs[11] = '{1'b1, 4'b0001, 4'b0001};

    addr = {12'h444, 12'h333, 12'h222, 12'h111};
    @(posedge clk); #1;
    for (int v = 0; v < 12; v++) begin
      rst_n = vecs[v].rst;
      req   = vecs[v].req;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
      if (!vecs[v].rst) begin
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
    end
    req = '0;
    repeat (6) begin @(posedge clk); #1; end

    // Single read on requester 2
    req = 4'b0100;
    addr[2*AW +: AW] = 12'h123;
    @(negedge clk);
    chk("single_grant", 32'(grant), 32'b0100);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("single_ram_addr", 32'(ram_addr), 32'h123);
    repeat (3) @(negedge clk);
    chk("single_valid", 32'(vld), 32'b0100);
    chk("single_data", 32'(dout), 32'hEDC);
    @(posedge clk); #1;

    // Round robin from a fresh reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    addr = {12'h3C3, 12'h2B2, 12'h1A1, 12'h090};
    for (int j = 0; j < 12; j++) begin
      req = (j < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      chk($sformatf("rr_grant%0d", j), 32'(grant), (j < 8) ? 32'(1 << (j % 4)) : 32'd0);
      if (j >= 4) begin
        chk($sformatf("rr_valid%0d", j), 32'(vld), 32'(1 << ((j - 4) % 4)));
        chk($sformatf("rr_data%0d", j), 32'(dout), 32'(addr[((j - 4) % 4)*AW +: AW] ^ 12'hFFF));
      end
      @(posedge clk); #1;
    end

    // Reset while two reads are in flight
    req = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1;
    req = 4'b0010;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("mid_valid_t2", 32'(vld), 32'd0);
    chk("mid_busy_t2", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("mid_valid_t%0d", k), 32'(vld), 32'd0);
      chk($sformatf("mid_busy_t%0d", k), 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    // Random traffic with gaps, checked by the scoreboard
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      g = grant;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!req[i] || g[i]) begin
          req[i] = ($urandom_range(0, 99) < 40);
          if (req[i]) addr[i*AW +: AW] = AW'($urandom);
        end else if ($urandom_range(0, 49) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    repeat (8) @(negedge clk);
    chk("drain_queue_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin arbiter that shares one sprite/texture BRAM read port among NUM_REQ sprite renderers: game objects, katana overlay and future sprites. Each requester presents a read address. The block grants one requester per cycle, drives the BRAM address, and routes returned data back to the granted requester with a one-hot valid tag. It sits between the per-object sprite renderers and the single shared sprite ROM, on the 65 MHz pixel clock.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 12: BRAM address width.
- DATA_WIDTH, 12: BRAM word width (444 RGB).
- RAM_LATENCY, 2: cycles from `ram_addr_out` to matching `ram_data_in`, 1..4.

Ports:
- clk_in  input  1  pixel clock (65 MHz).
- rst_in  input  1  synchronous, active-low reset.
- req_in  input  NUM_REQ  per-requester read request, level; held until granted.
- addr_in  input  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]; stable while req_in[i] is high.
- grant_out  output  NUM_REQ  one-hot combinational grant, all-zero when no request.
- ram_addr_out  output  ADDR_WIDTH  registered BRAM read address.
- ram_data_in  input  DATA_WIDTH  BRAM read data.
- data_out  output  DATA_WIDTH  registered return data, shared bus.
- valid_out  output  NUM_REQ  registered one-hot: data_out belongs to requester i.
- busy_out  output  1  high while any grant is in flight (tag pipeline non-empty).

## Operation
- Transfer rule: a read is accepted in any cycle where req_in[i] & grant_out[i]. The requester may drop or change its request on the next cycle.
- Arbitration:
  - Combinational search over req_in, starting at pointer `ptr` and wrapping modulo NUM_REQ. The first set bit is granted.
  - At most one grant per cycle.
  - A requester that is not granted keeps requesting and is not lost.
- Pointer update: on an accepted transfer to index g, `ptr <= (g+1) mod NUM_REQ`. With no transfer, ptr holds.
- Fairness: a continuously requesting index is granted within NUM_REQ cycles.
- Address path: on acceptance, `ram_addr_out <= addr_in[g]`. Otherwise ram_addr_out holds its previous value; the BRAM is read every cycle, but unmatched data is ignored.
- Tag pipeline:
  - Depth RAM_LATENCY+1, one-hot NUM_REQ wide.
  - Stage 0 loads grant_out & req_in each cycle (zero when idle). Stages shift every cycle; there is no backpressure.
  - When the final stage is non-zero, `data_out <= ram_data_in` and `valid_out <=` that stage.
  - When the final stage is zero, `valid_out <= 0` and data_out holds.
- busy_out = OR of all tag stages.
- Reset (rst_in low at a clock edge):
  - ptr=0, ram_addr_out=0, data_out=0, valid_out=0, all tag stages=0, busy_out=0.
  - grant_out is forced to 0 while rst_in is low.
- Reset mid-operation drops in-flight tags. No valid_out pulse is produced for reads accepted before reset.

## Timing
- Grant latency: 0 cycles (combinational from req_in and ptr).
- Accepted in cycle T:
  - ram_addr_out valid in T+1.
  - ram_data_in valid in T+1+RAM_LATENCY.
  - data_out/valid_out in T+2+RAM_LATENCY. This is T+4 at default.
- Throughput: one read per cycle sustained. Back-to-back grants to different requesters return back-to-back valid_out pulses in grant order.
- Simultaneous requests: the lowest index at or after ptr (with wrap) wins.
- Single requester: granted every cycle it requests. The pointer still advances past it, which is harmless.
- Requester dropping req_in without a grant: allowed; no read is issued.
- Renderers must pre-fetch RAM_LATENCY+2+(NUM_REQ-1) cycles ahead of the pixel they draw. Top level pipelines hcount/vcount accordingly.

## Test plan
- Reset: hold rst_in=0 for 3 cycles with req_in=4'b1111. Required: grant_out=0, valid_out=0, ram_addr_out=0, busy_out=0. First grant after release goes to index 0.
- Single read: req_in=4'b0100, addr 0x123, RAM model returns addr^0xFFF. Required: grant_out=4'b0100 same cycle; ram_addr_out=0x123 at T+1; valid_out=4'b0100 and data_out=0xEDC at T+4.
- Round-robin: all four requesters held high for 8 cycles. Required: grant sequence 0,1,2,3,0,1,2,3; valid_out sequence is the same, shifted by 4 cycles, each carrying its own address's data.
- Wrap/priority: ptr=3 after a grant to index 2, then req_in=4'b1001. Required: index 3 is granted, then index 0.
- Reset mid-flight: grants at T and T+1, rst_in low at T+2. Required: no valid_out through T+6; busy_out=0 from T+3.
- Idle gaps: requests with random gaps over 1000 cycles, checked against a scoreboard. Required: each accepted read yields exactly one valid_out with the correct data. No requester waits more than 4 cycles.
